// File: rtl/interval_timer_ctrl_if.sv
// Timer control/programming bus between the light-sequencing FSM (master) and
// interval_timer_ctrl (slave).
interface interval_timer_ctrl_if #(
  parameter int VAL_W = 4,
  parameter int CNT_W = 5
);
  logic             start_timer;
  logic [1:0]       interval;
  logic             Prog_Sync;
  logic [1:0]       Time_Param_Selector;
  logic [VAL_W-1:0] Time_Value;
  logic             expired;
  logic             busy;
  logic [CNT_W-1:0] count_remaining;

  modport master (
    output start_timer, interval, Prog_Sync, Time_Param_Selector, Time_Value,
    input  expired, busy, count_remaining
  );

  modport slave (
    input  start_timer, interval, Prog_Sync, Time_Param_Selector, Time_Value,
    output expired, busy, count_remaining
  );
endinterface

// File: rtl/interval_timer_ctrl.sv
// Programmable interval timer: holds tBASE/tEXT/tYEL and runs the 1 Hz countdown.
// Define TIMER_FAST_SIM_EN to decrement on every clk instead of one_hz_enable.
//
//   state | meaning
//   IDLE  | no interval running, count_remaining = 0
//   COUNT | counting down the loaded interval
module interval_timer_ctrl #(
  parameter int VAL_W    = 4,
  parameter int CNT_W    = 5,
  parameter int DEF_BASE = 6,
  parameter int DEF_EXT  = 3,
  parameter int DEF_YEL  = 2
) (
  input  logic                  clk,
  input  logic                  Reset_Sync,
  input  logic                  one_hz_enable,
  interval_timer_ctrl_if.slave  tmr
);

  typedef enum logic {IDLE, COUNT} state_t;

  localparam logic [VAL_W-1:0] DEF_BASE_V = VAL_W'(DEF_BASE);
  localparam logic [VAL_W-1:0] DEF_EXT_V  = VAL_W'(DEF_EXT);
  localparam logic [VAL_W-1:0] DEF_YEL_V  = VAL_W'(DEF_YEL);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expired_q, expired_d;
  logic             busy_q, busy_d;
  logic [VAL_W-1:0] tbase_q, tbase_d;
  logic [VAL_W-1:0] text_q, text_d;
  logic [VAL_W-1:0] tyel_q, tyel_d;
  logic [CNT_W-1:0] load_val;
  logic             tick;

`ifdef TIMER_FAST_SIM_EN
  logic unused_one_hz;
  assign unused_one_hz = one_hz_enable;
  assign tick          = 1'b1;
`else
  assign tick = one_hz_enable;
`endif

  // Load always uses the registered params, so a same-edge reprogram is not seen.
  always_comb begin
    load_val = '0;
    case (tmr.interval)
      2'b00:   load_val = CNT_W'(tbase_q);
      2'b01:   load_val = CNT_W'(text_q);
      2'b10:   load_val = CNT_W'(tyel_q);
      default: load_val = CNT_W'(tbase_q) << 1;
    endcase
  end

  always_comb begin
    tbase_d = tbase_q;
    text_d  = text_q;
    tyel_d  = tyel_q;
    if (tmr.Prog_Sync) begin
      case (tmr.Time_Param_Selector)
        2'b00:   tbase_d = (tmr.Time_Value == '0) ? DEF_BASE_V : tmr.Time_Value;
        2'b01:   text_d  = (tmr.Time_Value == '0) ? DEF_EXT_V  : tmr.Time_Value;
        2'b10:   tyel_d  = (tmr.Time_Value == '0) ? DEF_YEL_V  : tmr.Time_Value;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    expired_d = 1'b0;
    if (tmr.start_timer) begin
      state_d = COUNT;
      cnt_d   = load_val;
      busy_d  = 1'b1;
    end else if (state_q == COUNT) begin
      if (cnt_q == '0) begin
        // Zero load is unreachable with the zero-substitution, but must not hang.
        state_d   = IDLE;
        busy_d    = 1'b0;
        expired_d = 1'b1;
      end else if (tick) begin
        if (cnt_q == CNT_W'(1)) begin
          state_d   = IDLE;
          cnt_d     = '0;
          busy_d    = 1'b0;
          expired_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (Reset_Sync) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      expired_q <= 1'b0;
      tbase_q   <= DEF_BASE_V;
      text_q    <= DEF_EXT_V;
      tyel_q    <= DEF_YEL_V;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      expired_q <= expired_d;
      tbase_q   <= tbase_d;
      text_q    <= text_d;
      tyel_q    <= tyel_d;
    end
  end

  assign tmr.expired         = expired_q;
  assign tmr.busy            = busy_q;
  assign tmr.count_remaining = cnt_q;

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Scoreboard bench for interval_timer_ctrl: each completing run pushes the tick
// count at which its expired pulse is due; a monitor pops on every pulse.
module tb_interval_timer_ctrl;

  logic clk = 1'b0;
  logic Reset_Sync = 1'b1;
  logic one_hz_enable = 1'b0;

  interval_timer_ctrl_if #(.VAL_W(4), .CNT_W(5)) bus ();

  interval_timer_ctrl dut (
    .clk          (clk),
    .Reset_Sync   (Reset_Sync),
    .one_hz_enable(one_hz_enable),
    .tmr          (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tag;
    int ticks;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   tick_cnt = 0;
  int   tag_id   = 0;
  logic prev_exp = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    one_hz_enable = 1'b1;
    tick_cnt++;
    @(negedge clk);
    one_hz_enable = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // n > 0: this run is expected to complete n ticks after the load
  task automatic start(input logic [1:0] iv, input int n);
    @(negedge clk);
    bus.start_timer = 1'b1;
    bus.interval    = iv;
    if (n > 0) begin
      sb.push_back('{tag_id, tick_cnt + n});
      tag_id++;
    end
    @(negedge clk);
    bus.start_timer = 1'b0;
  endtask

  task automatic prog(input logic [1:0] sel, input logic [3:0] val);
    @(negedge clk);
    bus.Prog_Sync           = 1'b1;
    bus.Time_Param_Selector = sel;
    bus.Time_Value          = val;
    @(negedge clk);
    bus.Prog_Sync = 1'b0;
  endtask

  // Monitor: every expired pulse must match the oldest expected completion.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (prev_exp) chk("expired_one_cycle", int'(bus.expired), 0);
      if (bus.expired) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_expired: got pulse at tick %0d expected none", tick_cnt);
        end else begin
          e = sb.pop_front();
          chk($sformatf("expire_tick_run%0d", e.tag), tick_cnt, e.ticks);
        end
      end
      prev_exp = bus.expired;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start_timer         = 1'b0;
    bus.interval            = 2'b00;
    bus.Prog_Sync           = 1'b0;
    bus.Time_Param_Selector = 2'b00;
    bus.Time_Value          = 4'd0;
    repeat (3) @(negedge clk);
    Reset_Sync = 1'b0;
    @(negedge clk);
    chk("rst_count", int'(bus.count_remaining), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_expired", int'(bus.expired), 0);

    // default tBASE = 6, observe the full countdown
    start(2'b00, 6);
    chk("base_load", int'(bus.count_remaining), 6);
    chk("base_busy", int'(bus.busy), 1);
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk($sformatf("base_cnt_t%0d", i), int'(bus.count_remaining), 6 - i);
      chk($sformatf("base_busy_t%0d", i), int'(bus.busy), (i < 6) ? 1 : 0);
    end

    // tEXT = 9, then zero write restores default 3
    prog(2'b01, 4'd9);
    start(2'b01, 9);
    chk("ext9_load", int'(bus.count_remaining), 9);
    ticks(9);
    prog(2'b01, 4'd0);
    start(2'b01, 3);
    chk("ext_def_load", int'(bus.count_remaining), 3);
    ticks(3);

    // 2*tBASE with tBASE = 15
    prog(2'b00, 4'd15);
    start(2'b11, 30);
    chk("dbl_load", int'(bus.count_remaining), 30);
    ticks(30);
    chk("dbl_busy_after", int'(bus.busy), 0);

    // restart discards running interval
    start(2'b00, 0);
    ticks(2);
    chk("restart_mid", int'(bus.count_remaining), 13);
    start(2'b10, 2);
    chk("restart_load", int'(bus.count_remaining), 2);
    ticks(2);

    // reprogramming does not touch a running count
    prog(2'b00, 4'd0);
    start(2'b00, 6);
    tick();
    prog(2'b00, 4'd4);
    chk("prog_run_cnt", int'(bus.count_remaining), 5);
    ticks(5);
    start(2'b00, 4);
    chk("prog_next_load", int'(bus.count_remaining), 4);
    ticks(4);
    prog(2'b11, 4'd9);
    start(2'b00, 0);
    chk("sel11_base", int'(bus.count_remaining), 4);
    start(2'b01, 0);
    chk("sel11_ext", int'(bus.count_remaining), 3);
    start(2'b10, 2);
    chk("sel11_yel", int'(bus.count_remaining), 2);
    ticks(2);

    // same-edge program and start on tYEL: load sees old value
    @(negedge clk);
    bus.Prog_Sync           = 1'b1;
    bus.Time_Param_Selector = 2'b10;
    bus.Time_Value          = 4'd7;
    bus.start_timer         = 1'b1;
    bus.interval            = 2'b10;
    sb.push_back('{tag_id, tick_cnt + 2});
    tag_id++;
    @(negedge clk);
    bus.Prog_Sync   = 1'b0;
    bus.start_timer = 1'b0;
    chk("same_edge_old", int'(bus.count_remaining), 2);
    ticks(2);
    start(2'b10, 7);
    chk("same_edge_new", int'(bus.count_remaining), 7);
    ticks(7);

    // reset mid-count aborts silently and restores defaults
    start(2'b00, 0);
    tick();
    chk("pre_rst_cnt", int'(bus.count_remaining), 3);
    @(negedge clk);
    Reset_Sync = 1'b1;
    @(negedge clk);
    Reset_Sync = 1'b0;
    chk("midrst_count", int'(bus.count_remaining), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    ticks(2);
    chk("midrst_idle_cnt", int'(bus.count_remaining), 0);
    start(2'b10, 0);
    chk("midrst_yel_def", int'(bus.count_remaining), 2);
    tick();
    chk("pre_coinc_cnt", int'(bus.count_remaining), 1);

    // start coincident with terminal tick: reload, no pulse
    @(negedge clk);
    one_hz_enable   = 1'b1;
    bus.start_timer = 1'b1;
    bus.interval    = 2'b01;
    tick_cnt++;
    @(negedge clk);
    one_hz_enable   = 1'b0;
    bus.start_timer = 1'b0;
    sb.push_back('{tag_id, tick_cnt + 3});
    tag_id++;
    chk("coinc_load", int'(bus.count_remaining), 3);
    chk("coinc_busy", int'(bus.busy), 1);
    ticks(3);

    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
